// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Zero divisor completes in one edge with an all-ones quotient.
module seq_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [W-1:0]   dvs;
   logic [W-1:0]   rem;
   logic [W-1:0]   quo_sh;
   logic [CW-1:0]  cnt;
   logic [W:0]     trial;
   logic [W:0]     diff;
   logic           fits;
   logic [W-1:0]   rem_step;
   logic [W-1:0]   quo_step;
   logic           last;

   // Partial remainder is W+1 bits; diff's top bit is the borrow.
   always_comb begin
      trial    = {rem, quo_sh[W-1]};
      diff     = trial - {1'b0, dvs};
      fits     = ~diff[W];
      rem_step = fits ? diff[W-1:0] : trial[W-1:0];
      quo_step = {quo_sh[W-2:0], fits};
      last     = (cnt == CW'(W - 1));
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = (divisor == '0) ? DONE : CALC;
         CALC: if (last) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dvs         <= '0;
         rem         <= '0;
         quo_sh      <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  dvs    <= divisor;
                  quo_sh <= dividend;
                  rem    <= '0;
                  cnt    <= '0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     busy <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem    <= rem_step;
               quo_sh <= quo_step;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  quotient    <= quo_step;
                  remainder   <= rem_step;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
